// File: rtl/d8m_camera_emulator.sv
`default_nettype none
// ============================================================================
// Module      : d8m_camera_emulator
// Description : Sensor-side parallel camera transmitter (12-bit D, FVAL, LVAL)
//               producing raster frames with programmable blanking and test
//               patterns for exercising the capture chain without a sensor.
// Revision    : 1.0 - initial release
// ============================================================================
module d8m_camera_emulator #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 160,
  parameter int V_BLANK  = 45,
  parameter int FV_LEAD  = 4,
  parameter int FV_TRAIL = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [11:0] const_val,
  output logic [11:0] cam_d,
  output logic        cam_fval,
  output logic        cam_lval,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_LINE  = 3'd2,
    ST_HBL   = 3'd3,
    ST_TRAIL = 3'd4,
    ST_VBL   = 3'd5
  } state_t;

  // Terminal values of the position and phase counters.
  localparam logic [15:0] C_X_LAST     = 16'(H_ACTIVE - 1);
  localparam logic [15:0] C_Y_LAST     = 16'(V_ACTIVE - 1);
  localparam logic [15:0] C_LEAD_LAST  = 16'(FV_LEAD - 1);
  localparam logic [15:0] C_HBL_LAST   = 16'(H_BLANK - 1);
  localparam logic [15:0] C_TRAIL_LAST = 16'(FV_TRAIL - 1);
  localparam logic [15:0] C_VBL_LAST   = 16'(V_BLANK - 1);

  state_t      state_q, state_d;
  logic [15:0] ctr_q, ctr_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [1:0]  mode_q, mode_d;
  logic [11:0] const_q, const_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [11:0] cam_d_q, cam_d_d;
  logic        cam_fval_q, cam_fval_d;
  logic        cam_lval_q, cam_lval_d;
  logic        busy_q, busy_d;
  logic        start_frame;
  logic [11:0] pix;

  // State, counters, latched pattern settings and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ctr_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= '0;
      const_q     <= '0;
      frame_cnt_q <= '0;
      cam_d_q     <= '0;
      cam_fval_q  <= 1'b0;
      cam_lval_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      mode_q      <= mode_d;
      const_q     <= const_d;
      frame_cnt_q <= frame_cnt_d;
      cam_d_q     <= cam_d_d;
      cam_fval_q  <= cam_fval_d;
      cam_lval_q  <= cam_lval_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state sequencing through the raster; outputs are derived from the
  // next state so the registered outputs line up with the current state.
  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    x_d         = x_q;
    y_d         = y_q;
    mode_d      = mode_q;
    const_d     = const_q;
    frame_cnt_d = frame_cnt_q;
    start_frame = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) start_frame = 1'b1;
      end
      ST_LEAD: begin
        if (ctr_q == C_LEAD_LAST) begin
          state_d = ST_LINE;
          ctr_d   = '0;
          x_d     = '0;
          y_d     = '0;
        end else begin
          ctr_d = ctr_q + 16'd1;
        end
      end
      ST_LINE: begin
        if (x_q == C_X_LAST) begin
          ctr_d   = '0;
          state_d = (y_q == C_Y_LAST) ? ST_TRAIL : ST_HBL;
        end else begin
          x_d = x_q + 16'd1;
        end
      end
      ST_HBL: begin
        if (ctr_q == C_HBL_LAST) begin
          state_d = ST_LINE;
          ctr_d   = '0;
          x_d     = '0;
          y_d     = y_q + 16'd1;
        end else begin
          ctr_d = ctr_q + 16'd1;
        end
      end
      ST_TRAIL: begin
        if (ctr_q == C_TRAIL_LAST) begin
          state_d     = ST_VBL;
          ctr_d       = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          ctr_d = ctr_q + 16'd1;
        end
      end
      ST_VBL: begin
        if (ctr_q == C_VBL_LAST) begin
          ctr_d = '0;
          if (enable) start_frame = 1'b1;
          else        state_d     = ST_IDLE;
        end else begin
          ctr_d = ctr_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ctr_d   = '0;
      end
    endcase

    // Pattern settings are only captured at a frame start.
    if (start_frame) begin
      state_d = ST_LEAD;
      ctr_d   = '0;
      mode_d  = mode;
      const_d = const_val;
    end

    // The latched mode is already stable by the time LINE is reached.
    pix = '0;
    case (mode_q)
      2'd0:    pix = {x_d[9:0], 2'b00};
      2'd1:    pix = (!y_d[0] && x_d[0]) ? 12'hFFF : 12'h000;
      2'd2:    pix = (x_d[3] ^ y_d[3]) ? 12'hFFF : 12'h000;
      default: pix = const_q;
    endcase

    cam_lval_d = (state_d == ST_LINE);
    cam_fval_d = (state_d == ST_LEAD) || (state_d == ST_LINE) ||
                 (state_d == ST_HBL)  || (state_d == ST_TRAIL);
    busy_d     = (state_d != ST_IDLE);
    cam_d_d    = cam_lval_d ? pix : 12'h000;
  end

  assign cam_d     = cam_d_q;
  assign cam_fval  = cam_fval_q;
  assign cam_lval  = cam_lval_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_d8m_camera_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_d8m_camera_emulator
// Description : Self-checking bench for d8m_camera_emulator. A frame-position
//               reference model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d8m_camera_emulator;

  // Width 16 and height 10 so both x[3] and y[3] of the checkerboard toggle.
  localparam int H_ACTIVE = 16;
  localparam int V_ACTIVE = 10;
  localparam int H_BLANK  = 3;
  localparam int V_BLANK  = 5;
  localparam int FV_LEAD  = 2;
  localparam int FV_TRAIL = 2;
  localparam int LINE_LEN = H_ACTIVE + H_BLANK;
  localparam int FVH      = FV_LEAD + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + FV_TRAIL;
  localparam int PERIOD   = FVH + V_BLANK;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  mode;
  logic [11:0] const_val;
  logic [11:0] cam_d;
  logic        cam_fval;
  logic        cam_lval;
  logic [15:0] frame_cnt;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position within the current frame (-1 when idle).
  int          m_t = -1;
  logic [1:0]  m_mode;
  logic [11:0] m_const;
  logic [15:0] m_fcnt;

  d8m_camera_emulator #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .V_BLANK(V_BLANK), .FV_LEAD(FV_LEAD), .FV_TRAIL(FV_TRAIL)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
    .const_val(const_val), .cam_d(cam_d), .cam_fval(cam_fval),
    .cam_lval(cam_lval), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_pix(input logic [1:0] md, input logic [11:0] cv,
                                          input int col, input int row);
    case (md)
      2'd0:    return 12'((col % 1024) * 4);
      2'd1:    return ((row % 2 == 0) && (col % 2 == 1)) ? 12'hFFF : 12'h000;
      2'd2:    return (((col / 8) % 2) != ((row / 8) % 2)) ? 12'hFFF : 12'h000;
      default: return cv;
    endcase
  endfunction

  // Frame-position model: a frame starts when enable is seen while idle or
  // at the final V_BLANK cycle; the count bumps as FVAL drops.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_t     <= -1;
      m_mode  <= 2'd0;
      m_const <= 12'd0;
      m_fcnt  <= 16'd0;
    end else if (m_t < 0 || m_t == PERIOD-1) begin
      if (enable) begin
        m_t     <= 0;
        m_mode  <= mode;
        m_const <= const_val;
      end else begin
        m_t <= -1;
      end
    end else begin
      m_t <= m_t + 1;
      if (m_t == FVH-1) m_fcnt <= m_fcnt + 16'd1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int p;
    logic e_f, e_l, e_b;
    logic [11:0] e_d;
    e_f = (m_t >= 0) && (m_t < FVH);
    e_b = (m_t >= 0);
    e_l = 1'b0;
    e_d = 12'h000;
    if (m_t >= FV_LEAD && m_t < FVH - FV_TRAIL) begin
      p = m_t - FV_LEAD;
      if ((p % LINE_LEN) < H_ACTIVE) begin
        e_l = 1'b1;
        e_d = ref_pix(m_mode, m_const, p % LINE_LEN, p / LINE_LEN);
      end
    end
    chk("fval", cam_fval, e_f);
    chk("lval", cam_lval, e_l);
    chk("busy", busy, e_b);
    chk("data", cam_d, e_d);
    chk("fcnt", frame_cnt, m_fcnt);
  end

  // Called on a negedge; measures one complete FVAL-high/low interval.
  task automatic measure_frame();
    int hi, lo, lines, lead, guard;
    logic prev_l;
    hi = 0; lo = 0; lines = 0; lead = -1; guard = 0; prev_l = 1'b0;
    while (!cam_fval && guard < 2*PERIOD) begin guard++; @(negedge clk); end
    chk("meas_fval_rise", cam_fval, 1);
    while (cam_fval && hi < 2*PERIOD) begin
      if (cam_lval && !prev_l) begin
        lines++;
        if (lead < 0) lead = hi;
      end
      prev_l = cam_lval;
      hi++;
      @(negedge clk);
    end
    chk("meas_fval_high", hi, FVH);
    chk("meas_lead", lead, FV_LEAD);
    chk("meas_lines", lines, V_ACTIVE);
    while (!cam_fval && lo < 2*PERIOD) begin lo++; @(negedge clk); end
    chk("meas_fval_low", lo, V_BLANK);
  endtask

  // Called on a negedge; leaves the bench on the negedge where FVAL rose.
  task automatic wait_fval_rise();
    int g;
    g = 0;
    while (cam_fval && g < 2*PERIOD) begin g++; @(negedge clk); end
    while (!cam_fval && g < 4*PERIOD) begin g++; @(negedge clk); end
    chk("wait_fval_rise", cam_fval, 1);
  endtask

  initial begin
    int cnt, fv, g;
    logic [15:0] fc0;

    reset_n = 1'b0; enable = 1'b0; mode = 2'd0; const_val = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d", cam_d, 0);
    chk("rst_fval", cam_fval, 0);
    chk("rst_lval", cam_lval, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_busy", busy, 0);

    // Continuous ramp frames: timing, line count, frame counter.
    reset_n = 1'b1; enable = 1'b1; mode = 2'd0;
    @(negedge clk);
    measure_frame();
    measure_frame();
    measure_frame();
    chk("fcnt_after3", frame_cnt, 3);

    // Mid-frame pattern changes only take effect on the next frame.
    @(posedge clk); #1; mode = 2'd1;
    repeat (PERIOD) @(negedge clk);
    @(posedge clk); #1; mode = 2'd3; const_val = 12'hA5C;
    repeat (PERIOD) @(negedge clk);
    @(posedge clk); #1; mode = 2'd0;
    @(negedge clk);
    wait_fval_rise();
    repeat (FV_LEAD + 2*LINE_LEN + 3) @(negedge clk);
    @(posedge clk); #1; mode = 2'd2;
    repeat (2*PERIOD) @(negedge clk);

    // Enable dropped during line 1: frame and V_BLANK still complete.
    wait_fval_rise();
    fc0 = frame_cnt;
    cnt = 0;
    while (busy && cnt < 2*PERIOD) begin
      cnt++;
      if (cnt == FV_LEAD + LINE_LEN + 2) begin
        @(posedge clk); #1; enable = 1'b0; mode = 2'd1;
      end
      @(negedge clk);
    end
    chk("drop_busy_len", cnt, PERIOD);
    chk("drop_fval", cam_fval, 0);
    chk("drop_fcnt", frame_cnt, fc0 + 16'd1);
    repeat (10) @(negedge clk);
    chk("drop_stays_idle", busy, 0);

    // Single-cycle enable pulse from IDLE yields exactly one frame.
    fc0 = frame_cnt;
    @(posedge clk); #1; enable = 1'b1; mode = 2'd3; const_val = 12'h3C5;
    @(posedge clk); #1; enable = 1'b0;
    @(negedge clk);
    cnt = 0; fv = 0;
    while (busy && cnt < 2*PERIOD) begin
      cnt++;
      if (cam_fval) fv++;
      @(negedge clk);
    end
    chk("single_busy_len", cnt, PERIOD);
    chk("single_fval_len", fv, FVH);
    chk("single_fcnt", frame_cnt, fc0 + 16'd1);

    // Reset asserted while LVAL is high clears everything at once.
    @(posedge clk); #1; enable = 1'b1; mode = 2'd0;
    g = 0;
    @(negedge clk);
    while (!cam_lval && g < 2*PERIOD) begin g++; @(negedge clk); end
    chk("rst_mid_lval_seen", cam_lval, 1);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_d", cam_d, 0);
    chk("arst_fval", cam_fval, 0);
    chk("arst_lval", cam_lval, 0);
    chk("arst_fcnt", frame_cnt, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk); #1;
    mode = 2'd3; const_val = 12'($urandom);
    reset_n = 1'b1;
    @(negedge clk);
    measure_frame();
    chk("post_rst_fcnt", frame_cnt, 1);

    // Randomised run: enable toggles and pattern changes at arbitrary times.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (i % 60 == 0) enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 31) == 0) begin
        mode      = 2'($urandom_range(0, 3));
        const_val = 12'($urandom);
      end
    end
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
